// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package pipe_pkg;

  localparam int MAX_DEPTH      = 8;
  localparam int MAX_REG_W      = 8;  // tag register field width; REG_W must not exceed it
  localparam int ALU_READY_DEF  = 1;
  localparam int LOAD_READY_DEF = 2;

  localparam logic [3:0] FWD_RF = 4'd0;  // forward select: read the register file

  // Shadow of one pipeline stage downstream of decode
  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [MAX_REG_W-1:0] wreg;
    logic                 is_load;
  } stage_tag_t;

endpackage

// File: rtl/pipe_fwd_pick.sv
// Priority search over the stage tags for one source operand: the youngest
// in-flight writer of the source decides between forwarding and a hazard.
module pipe_fwd_pick
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ALU_READY  = ALU_READY_DEF,
  parameter int LOAD_READY = LOAD_READY_DEF
) (
  input  stage_tag_t [DEPTH-1:0] tags_i,
  input  logic [MAX_REG_W-1:0]   src_i,
  input  logic                   used_i,
  output logic [3:0]             sel_o,
  output logic                   hazard_o
);

  // Scan oldest to youngest so the youngest match is the last assignment
  always_comb begin
    sel_o    = FWD_RF;
    hazard_o = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (tags_i[k-1].valid && tags_i[k-1].wr_en && used_i &&
          (src_i != '0) && (tags_i[k-1].wreg == src_i)) begin
        if (k >= (tags_i[k-1].is_load ? LOAD_READY : ALU_READY)) begin
          sel_o    = 4'(k);
          hazard_o = 1'b0;
        end else begin
          sel_o    = FWD_RF;
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and bubble controller with a DEPTH-stage tag shadow of
// the pipeline after decode (stage 1 = EX ... stage DEPTH = WB).
// Optional: define PIPE_HAZARD_PERF_EN to add stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ALU_READY  = ALU_READY_DEF,
  parameter int LOAD_READY = LOAD_READY_DEF,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_redirect,
  input  logic             hold,
  output logic             stall,
  output logic             flush_fd,
  output logic [3:0]       fwd_sel_a,
  output logic [3:0]       fwd_sel_b,
  output logic [DEPTH-1:0] stage_valid
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  stage_tag_t [DEPTH-1:0]        tags_q, tags_d;
  stage_tag_t                    id_tag;
  logic [1:0][MAX_REG_W-1:0]     src;
  logic [1:0]                    used, hazard;
  logic [1:0][3:0]               sel;

  assign id_tag = '{valid:   id_valid,
                    wr_en:   id_wr_en,
                    wreg:    MAX_REG_W'(id_wr_reg),
                    is_load: id_is_load};

  assign src  = {MAX_REG_W'(id_rt), MAX_REG_W'(id_rs)};
  assign used = {id_rt_used, id_rs_used};

  // Operand 0 = source A (rs), operand 1 = source B (rt)
  for (genvar o = 0; o < 2; o++) begin : g_pick
    pipe_fwd_pick #(
      .DEPTH     (DEPTH),
      .ALU_READY (ALU_READY),
      .LOAD_READY(LOAD_READY)
    ) u_pick (
      .tags_i  (tags_q),
      .src_i   (src[o]),
      .used_i  (used[o]),
      .sel_o   (sel[o]),
      .hazard_o(hazard[o])
    );
  end

  assign fwd_sel_a = sel[0];
  assign fwd_sel_b = sel[1];
  assign stall     = hold | (id_valid & (|hazard));
  assign flush_fd  = id_redirect & ~stall;

  for (genvar k = 0; k < DEPTH; k++) begin : g_sv
    assign stage_valid[k] = tags_q[k].valid;
  end

  // Advance the tag shadow one stage; a stall injects a bubble into stage 1
  always_comb begin
    tags_d = tags_q;
    if (!hold) begin
      tags_d[0] = (id_valid && !stall) ? id_tag : '0;
      for (int k = 1; k < DEPTH; k++) tags_d[k] = tags_q[k-1];
    end
  end

  // Tag shadow state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tags_q <= '0;
    else       tags_q <= tags_d;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Cycle counters for hazard stalls (not external holds) and flushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !hold) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_fd)       flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default-parameter instance plus a
// DEPTH=5 / LOAD_READY=3 instance for the longer load-use case.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_redirect, hold;
  logic [4:0] id_rs, id_rt, id_wr_reg;

  logic       stall, flush_fd;
  logic [3:0] fwd_sel_a, fwd_sel_b;
  logic [3:0] stage_valid;

  logic       stall5, flush5;
  logic [3:0] sel_a5, sel_b5;
  logic [4:0] sv5;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_stall5, perf_flush5;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_redirect(id_redirect),
    .hold(hold), .stall(stall), .flush_fd(flush_fd), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .stage_valid(stage_valid)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  pipe_hazard_ctrl #(.DEPTH(5), .LOAD_READY(3)) u_dut5 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_redirect(id_redirect),
    .hold(hold), .stall(stall5), .flush_fd(flush5), .fwd_sel_a(sel_a5),
    .fwd_sel_b(sel_b5), .stage_valid(sv5)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall5), .perf_flush_cnt(perf_flush5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a decode-stage instruction (combinational outputs settle after #1)
  task automatic drive(input logic v, input int rs, input int rt, input logic rsu,
                       input logic rtu, input logic we, input int wr, input logic ld,
                       input logic rd);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_used = rsu; id_rt_used = rtu;
    id_wr_en = we; id_wr_reg = 5'(wr); id_is_load = ld; id_redirect = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hold = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush_fd), 0);
    chk("rst_sel_a", 32'(fwd_sel_a), 0);
    chk("rst_sel_b", 32'(fwd_sel_b), 0);
    chk("rst_sv", 32'(stage_valid), 0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("rst_perf_stall", perf_stall_cnt, 0);
    chk("rst_perf_flush", perf_flush_cnt, 0);
`endif

    // Back-to-back ALU: add $8,$1,$2 ; add $9,$8,$8
    drive(1, 1, 2, 1, 1, 1, 8, 0, 0);
    chk("alu1_stall", 32'(stall), 0);
    tick();
    drive(1, 8, 8, 1, 1, 1, 9, 0, 0);
    chk("alu2_stall", 32'(stall), 0);
    chk("alu2_sel_a", 32'(fwd_sel_a), 1);
    chk("alu2_sel_b", 32'(fwd_sel_b), 1);
    chk("alu2_sv", 32'(stage_valid), 4'b0001);
    tick();

    // Load-use, defaults: lw $8 ; add $9,$8,$0
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 8, 1, 0);
    tick();
    drive(1, 8, 0, 1, 1, 1, 9, 0, 0);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_sel_a_hz", 32'(fwd_sel_a), 0);
    chk("lu_sel_b_r0", 32'(fwd_sel_b), 0);
    tick();
    chk("lu_bubble_sv", 32'(stage_valid), 4'b0010);
    chk("lu_stall_clr", 32'(stall), 0);
    chk("lu_sel_a_fwd", 32'(fwd_sel_a), 2);
    tick();

    // Youngest wins: $8 writers at stages 1 and 3, then $0 reads
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0);   // young writer is a load -> not ready at stage 1
    tick();
    drive(1, 8, 0, 1, 0, 1, 0, 0, 0);   // reads $8, itself writes $0
    chk("yw_sv", 32'(stage_valid), 4'b0101);
    chk("yw_stall", 32'(stall), 1);      // youngest (load, stage 1) governs
    chk("yw_sel_a", 32'(fwd_sel_a), 0);
    tick();
    chk("yw2_sel_a", 32'(fwd_sel_a), 2); // load now at stage 2, ALU writer at 4
    chk("yw2_stall", 32'(stall), 0);
    tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);   // read $0,$0 with a $0 writer at stage 1
    chk("r0_sel_a", 32'(fwd_sel_a), 0);
    chk("r0_sel_b", 32'(fwd_sel_b), 0);
    chk("r0_stall", 32'(stall), 0);
    tick();

    // ALU youngest at stage 1 over older writer at stage 3
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
    tick();
    drive(1, 3, 8, 1, 1, 0, 0, 0, 0);
    chk("yw_alu_sel_b", 32'(fwd_sel_b), 1);
    chk("yw_alu_sel_a", 32'(fwd_sel_a), 0);
    tick();

    // Redirect: free flush, then a redirect hidden by a load-use stall
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rd_flush", 32'(flush_fd), 1);
    tick();
    drive(1, 1, 0, 1, 0, 1, 8, 1, 0);
    tick();
    drive(1, 8, 0, 1, 0, 0, 0, 0, 1);
    chk("rd_stall", 32'(stall), 1);
    chk("rd_flush_stall", 32'(flush_fd), 0);
    tick();
    chk("rd_flush_after", 32'(flush_fd), 1);
    chk("rd_sv", 32'(stage_valid), 4'b0110);
    tick();

    // Hold: three frozen cycles, stall forced, flush suppressed
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    hold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", 32'(stall), 1);
      chk("hold_flush", 32'(flush_fd), 0);
      chk("hold_sv", 32'(stage_valid), 4'b1101);
      tick();
    end
    chk("hold_sv_end", 32'(stage_valid), 4'b1101);
    hold = 1'b0; #1;

    // Asynchronous reset in the middle of a load-use stall
    drive(1, 1, 0, 1, 0, 1, 8, 1, 0);
    tick();
    drive(1, 8, 0, 1, 0, 0, 0, 0, 0);
    chk("ar_pre_stall", 32'(stall), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_sv", 32'(stage_valid), 0);
    chk("ar_stall", 32'(stall), 0);
    tick();
    reset = 1'b0;
    #1;

    // Load-use with DEPTH=5, LOAD_READY=3 (second instance)
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 8, 1, 0);
    tick();
    drive(1, 8, 0, 1, 0, 1, 9, 0, 0);
    chk("d5_stall1", 32'(stall5), 1);
    tick();
    chk("d5_stall2", 32'(stall5), 1);
    chk("d5_sv2", 32'(sv5), 5'b00010);
    tick();
    chk("d5_stall3", 32'(stall5), 0);
    chk("d5_sel_a", 32'(sel_a5), 3);
    chk("d5_sv3", 32'(sv5), 5'b00100);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
